// File: rtl/p2l_pkg.sv
// Shared encodings for the pulse-to-level converter: operating modes and FSM states.
package p2l_pkg;

    localparam logic [1:0] MODE_TOGGLE    = 2'b00;
    localparam logic [1:0] MODE_STRETCH   = 2'b01;
    localparam logic [1:0] MODE_HANDSHAKE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        GAP,
        WAIT_ACK_HI,
        WAIT_ACK_LO
    } p2l_state_t;

    // The reserved encoding behaves exactly like stretch.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_STRETCH : m;
    endfunction

endpackage

// File: rtl/p2l_pend_counter.sv
// Saturating up/down counter for pulses waiting to be converted.
module p2l_pend_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A simultaneous decrement makes room, so only a lone increment at the top is lost.
    always_comb begin
        sat_drop = inc && !dec && (count == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_to_level.sv
// Converts single-cycle pulses into CDC-safe levels (toggle, stretch or 4-phase handshake),
// queueing pulses that arrive while an earlier one is still being conveyed.
module pulse_to_level
    import p2l_pkg::*;
#(
    parameter int STRETCH_W = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse_in,
    input  logic [1:0]           mode,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic                 ack_in,
    input  logic                 ovf_clr,
    output logic                 level_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     pend_cnt,
    output logic                 overflow
);

    p2l_state_t           state;
    p2l_state_t           state_n;
    logic [1:0]           act_mode;
    logic [1:0]           eff_mode;
    logic [STRETCH_W-1:0] len_cnt;
    logic [STRETCH_W-1:0] len_n;
    logic                 level_n;
    logic                 start;
    logic                 eval;
    logic                 take;
    logic                 inc;
    logic                 dec;
    logic                 sat_drop;

    assign busy = (state != IDLE) || (pend_cnt != '0);

    // While idle the incoming mode governs this very edge, since it is latched on it.
    assign eff_mode = busy ? act_mode : norm_mode(mode);
    assign start    = pulse_in || (pend_cnt != '0);

    always_comb begin
        state_n = state;
        level_n = level_out;
        len_n   = len_cnt;
        eval    = 1'b0;
        take    = 1'b0;

        if (eff_mode == MODE_TOGGLE) begin
            state_n = IDLE;
            level_n = level_out ^ pulse_in;
        end else begin
            case (state)
                IDLE: begin
                    level_n = 1'b0;
                    eval    = 1'b1;
                end
                ASSERT: begin
                    if (len_cnt == '0) begin
                        state_n = GAP;
                        level_n = 1'b0;
                    end else begin
                        len_n = len_cnt - 1'b1;
                    end
                end
                GAP: begin
                    level_n = 1'b0;
                    eval    = 1'b1;
                end
                WAIT_ACK_HI: begin
                    if (ack_in) begin
                        state_n = WAIT_ACK_LO;
                        level_n = 1'b0;
                    end
                end
                WAIT_ACK_LO: begin
                    level_n = 1'b0;
                    eval    = !ack_in;
                end
                default: begin
                    state_n = IDLE;
                    level_n = 1'b0;
                end
            endcase

            if (eval) begin
                if (start) begin
                    take    = 1'b1;
                    level_n = 1'b1;
                    if (eff_mode == MODE_HANDSHAKE) begin
                        state_n = WAIT_ACK_HI;
                    end else begin
                        state_n = ASSERT;
                        len_n   = stretch_len;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
        end
    end

    // A pulse that starts a conversion directly from an empty queue is never counted.
    assign dec = take && (pend_cnt != '0);
    assign inc = pulse_in && (eff_mode != MODE_TOGGLE) && !(take && (pend_cnt == '0));

    p2l_pend_counter #(
        .CNT_W(CNT_W)
    ) u_pend (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .count    (pend_cnt),
        .sat_drop (sat_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            act_mode  <= MODE_TOGGLE;
            level_out <= 1'b0;
            len_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            level_out <= level_n;
            len_cnt   <= len_n;
            if (!busy) begin
                act_mode <= eff_mode;
            end
            if (sat_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
